// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port arbiter.
//   data_width() - RAM word width in bits, from bytes per word and bits per byte
//   req_t        - one requester's access: write flag, word address, write data, byte enables
// The field widths of req_t use the default block geometry. The top-level width
// parameters must match these defaults whenever req_t is used.
package ram_arb_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int BATCH_W_DEF = 4;
    localparam int BYTE_W_DEF  = 8;

    function automatic int data_width(input int batch_w, input int byte_w);
        return batch_w * byte_w;
    endfunction

    localparam int DW_DEF = data_width(BATCH_W_DEF, BYTE_W_DEF);

    typedef struct packed {
        logic                   write;
        logic [ADDR_W_DEF-1:0]  addr;
        logic [DW_DEF-1:0]      wdata;
        logic [BATCH_W_DEF-1:0] strb;
    } req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. This block has no state; the caller owns
// the priority pointer.
//   req       in   N   request vector
//   ptr       in   IW  index that has the highest priority this cycle
//   grant     out  N   one-hot grant (all zero when there is no request)
//   grant_idx out  IW  index of the granted requester (0 when there is no request)
//   any_req   out  1   at least one request present
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_req
);

    logic [IW-1:0] idx;

    // Scan from ptr upward, wrapping modulo N. The first requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = '0;
        for (int off = 0; off < N; off++) begin
            idx = IW'((int'(ptr) + off) % N);
            if (!any_req && req[idx]) begin
                any_req     = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between N_REQ requesters using round-robin arbitration.
// The block issues at most one access per cycle. RAM read data returns one
// cycle after issue. A response the requester does not accept is held until
// it is taken, and no new access issues while that response is pending.
//   clk, rst_n                 clock; synchronous active-low reset
//   req_valid/ready/write      per-requester request handshake and direction
//   req_addr/wdata/strb        packed per-requester address, write data, byte enables
//   rsp_valid/ready            per-requester response handshake
//   rsp_rdata                  shared response data, qualified by rsp_valid
//   ram_addr/wdata/byte_en/we  RAM port command
//   ram_rdata                  RAM port read data, one cycle after issue
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int ADDR_WIDTH  = ADDR_W_DEF,
    parameter int BATCH_WIDTH = BATCH_W_DEF,
    parameter int BYTE_WIDTH  = BYTE_W_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_REQ-1:0]                   req_valid,
    output logic [N_REQ-1:0]                   req_ready,
    input  logic [N_REQ-1:0]                   req_write,
    input  logic [N_REQ*ADDR_WIDTH-1:0]        req_addr,
    input  logic [N_REQ*BYTE_WIDTH*BATCH_WIDTH-1:0] req_wdata,
    input  logic [N_REQ*BATCH_WIDTH-1:0]       req_strb,
    output logic [N_REQ-1:0]                   rsp_valid,
    input  logic [N_REQ-1:0]                   rsp_ready,
    output logic [BYTE_WIDTH*BATCH_WIDTH-1:0]  rsp_rdata,
    output logic [ADDR_WIDTH-1:0]              ram_addr,
    output logic [BYTE_WIDTH*BATCH_WIDTH-1:0]  ram_wdata,
    output logic [BATCH_WIDTH-1:0]             ram_byte_en,
    output logic                               ram_we,
    input  logic [BYTE_WIDTH*BATCH_WIDTH-1:0]  ram_rdata
);

    localparam int DW = data_width(BATCH_WIDTH, BYTE_WIDTH);
    localparam int IW = $clog2(N_REQ);

    // Control state (reset)
    logic [IW-1:0] rr_ptr_q,     rr_ptr_d;
    logic          inflight_q,   inflight_d;
    logic          hold_valid_q, hold_valid_d;
    // Tags and data (not reset; qualified by the control bits above)
    logic [IW-1:0] inflight_id_q, inflight_id_d;
    logic          inflight_wr_q, inflight_wr_d;
    logic [IW-1:0] hold_id_q,     hold_id_d;
    logic [DW-1:0] hold_data_q,   hold_data_d;

    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    gidx;
    logic             any_req;
    req_t             win;
    logic [IW-1:0]    rsp_id;
    logic             pending;
    logic             rsp_fire;
    logic             can_issue;
    logic             issue;
    logic [DW-1:0]    live_rdata;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (gidx),
        .any_req   (any_req)
    );

    always_comb begin
        win.write = req_write[gidx];
        win.addr  = req_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
        win.wdata = req_wdata[int'(gidx)*DW +: DW];
        win.strb  = req_strb[int'(gidx)*BATCH_WIDTH +: BATCH_WIDTH];
    end

    // All handshakes are gated by rst_n. The reset is synchronous, so this
    // gating forces the outputs quiet during reset cycles.
    always_comb begin
        rsp_id     = hold_valid_q ? hold_id_q : inflight_id_q;
        pending    = (inflight_q | hold_valid_q) & rst_n;
        rsp_fire   = pending & rsp_ready[rsp_id];
        can_issue  = rst_n & (!(inflight_q | hold_valid_q) | rsp_fire);
        issue      = any_req & can_issue;
        live_rdata = inflight_wr_q ? '0 : ram_rdata;

        req_ready  = can_issue ? grant : '0;
        rsp_valid  = '0;
        rsp_valid[rsp_id] = pending;
        rsp_rdata  = '0;
        if (pending)
            rsp_rdata = hold_valid_q ? hold_data_q : live_rdata;

        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        ram_byte_en = '0;
        if (issue) begin
            ram_we      = win.write;
            ram_addr    = win.addr;
            ram_wdata   = win.wdata;
            ram_byte_en = win.strb;
        end
    end

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        inflight_d    = issue;
        inflight_id_d = inflight_id_q;
        inflight_wr_d = inflight_wr_q;
        hold_valid_d  = hold_valid_q;
        hold_id_d     = hold_id_q;
        hold_data_d   = hold_data_q;

        if (issue) begin
            inflight_id_d = gidx;
            inflight_wr_d = win.write;
            rr_ptr_d      = (int'(gidx) == N_REQ - 1) ? '0 : gidx + IW'(1);
        end

        // Read data is present on ram_rdata for only one cycle. Capture it
        // here if the requester does not take the response in that cycle.
        if (inflight_q && !rsp_fire) begin
            hold_valid_d = 1'b1;
            hold_id_d    = inflight_id_q;
            hold_data_d  = live_rdata;
        end else if (rsp_fire) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            inflight_q   <= 1'b0;
            hold_valid_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            inflight_q   <= inflight_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        inflight_id_q <= inflight_id_d;
        inflight_wr_q <= inflight_wr_d;
        hold_id_q     <= hold_id_d;
        hold_data_q   <= hold_data_d;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter (N_REQ=2) with a behavioural one-cycle RAM.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_strb;
    logic [1:0]  rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_byte_en;
    logic        ram_we;
    logic [31:0] ram_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    ram_port_arbiter #(.N_REQ(2), .ADDR_WIDTH(16), .BATCH_WIDTH(4), .BYTE_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_byte_en(ram_byte_en),
        .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    // Behavioural RAM: byte-enabled write and registered read (old data on a collision).
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
        ram_rdata = '0;
    end
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr[7:0]];
        if (ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_byte_en[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic w, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_write[i]          = w;
        req_addr[i*16 +: 16]  = a;
        req_wdata[i*32 +: 32] = d;
        req_strb[i*4 +: 4]    = s;
    endtask

    // Inputs change 1 time unit after the rising edge. Checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0;
        req_wdata = '0; req_strb = '0; rsp_ready = '0;
        cyc();
        req_valid = 2'b11;
        #1;
        chk("reset_req_ready", req_ready, 2'b00);
        chk("reset_ram_we", ram_we, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 2'b00);
        cyc();
        req_valid = '0;
        rst_n = 1'b1;
        cyc();
        #1;
        chk("idle_req_ready", req_ready, 2'b00);
        chk("idle_rsp_valid", rsp_valid, 2'b00);
        chk("idle_ram_we", ram_we, 1'b0);
        chk("idle_ram_addr", ram_addr, 16'h0);
        chk("idle_rsp_rdata", rsp_rdata, 32'h0);

        // Test 1: write by requester 0.
        set_req(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
        req_valid = 2'b01; rsp_ready = 2'b11;
        #1;
        chk("t1_req_ready", req_ready, 2'b01);
        chk("t1_ram_we", ram_we, 1'b1);
        chk("t1_ram_addr", ram_addr, 16'h0010);
        chk("t1_ram_wdata", ram_wdata, 32'hDEADBEEF);
        chk("t1_ram_byte_en", ram_byte_en, 4'hF);
        cyc();
        // Test 2: read back. The write ack fires in the same cycle.
        set_req(0, 1'b0, 16'h0010, 32'h0, 4'h0);
        #1;
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_rsp_rdata", rsp_rdata, 32'h0);
        chk("t2_req_ready", req_ready, 2'b01);
        chk("t2_ram_we", ram_we, 1'b0);
        cyc();
        // Test 3: both requesters valid. The pointer is 1, so requester 1 wins first.
        set_req(1, 1'b0, 16'h0020, 32'h0, 4'h0);
        req_valid = 2'b11;
        #1;
        chk("t2_rsp_valid", rsp_valid, 2'b01);
        chk("t2_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            logic [1:0] eg;
            eg = (i % 2 == 0) ? 2'b10 : 2'b01;
            chk($sformatf("t3_grant%0d", i), req_ready, eg);
            chk($sformatf("t3_addr%0d", i), ram_addr, (eg == 2'b10) ? 16'h0020 : 16'h0010);
            cyc();
            #1;
            chk($sformatf("t3_rsp_valid%0d", i), rsp_valid, eg);
            chk($sformatf("t3_rsp_rdata%0d", i), rsp_rdata,
                (eg == 2'b10) ? 32'hA000_0020 : 32'hDEADBEEF);
        end

        // Test 4: stall the pending response from requester 0 for 3 cycles.
        rsp_ready = 2'b00;
        req_valid = 2'b10;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t4_req_ready%0d", i), req_ready, 2'b00);
            chk($sformatf("t4_rsp_valid%0d", i), rsp_valid, 2'b01);
            chk($sformatf("t4_rsp_rdata%0d", i), rsp_rdata, 32'hDEADBEEF);
            chk($sformatf("t4_ram_we%0d", i), ram_we, 1'b0);
            cyc();
            #1;
        end
        rsp_ready = 2'b01;
        #1;
        chk("t4_release_valid", rsp_valid, 2'b01);
        chk("t4_release_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("t4_release_grant", req_ready, 2'b10);
        chk("t4_release_addr", ram_addr, 16'h0020);
        cyc();
        // Test 5: the pointer is 0 and only requester 1 is valid. It issues a partial write.
        set_req(1, 1'b1, 16'h0030, 32'h11223344, 4'b0101);
        rsp_ready = 2'b11;
        #1;
        chk("t4_new_rsp_valid", rsp_valid, 2'b10);
        chk("t4_new_rsp_rdata", rsp_rdata, 32'hA000_0020);
        chk("t5_grant", req_ready, 2'b10);
        chk("t5_ram_we", ram_we, 1'b1);
        chk("t5_byte_en", ram_byte_en, 4'b0101);
        cyc();
        // The pointer wrapped to 0, so requester 0 wins with both valid.
        set_req(0, 1'b0, 16'h0030, 32'h0, 4'h0);
        set_req(1, 1'b0, 16'h0020, 32'h0, 4'h0);
        req_valid = 2'b11;
        #1;
        chk("t5_rsp_valid", rsp_valid, 2'b10);
        chk("t5_rsp_rdata", rsp_rdata, 32'h0);
        chk("t5_wrap_grant", req_ready, 2'b01);
        cyc();
        set_req(0, 1'b0, 16'h0010, 32'h0, 4'h0);
        req_valid = 2'b01;
        #1;
        chk("t5_partial_rdata", rsp_rdata, 32'hA022_0044);
        chk("t5_r0_grant", req_ready, 2'b01);
        cyc();
        // Test 6: the pointer is now 1. Hold the response, then reset.
        req_valid = 2'b00; rsp_ready = 2'b00;
        #1;
        chk("t6_pre_valid", rsp_valid, 2'b01);
        cyc();
        #1;
        chk("t6_hold_valid", rsp_valid, 2'b01);
        chk("t6_hold_rdata", rsp_rdata, 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        chk("t6_inreset_valid", rsp_valid, 2'b00);
        cyc();
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        #1;
        chk("t6_post_valid", rsp_valid, 2'b00);
        chk("t6_ptr_reset_grant", req_ready, 2'b01);
        chk("t6_post_addr", ram_addr, 16'h0010);
        cyc();
        req_valid = 2'b00;
        #1;
        chk("t6_first_rsp_valid", rsp_valid, 2'b01);
        chk("t6_first_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        cyc();
        #1;
        chk("final_idle_valid", rsp_valid, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
